// File: rtl/down_timer.sv
// Loadable MM:SS countdown timer: a num-cycle divider produces one-second ticks that count min/sec down to 00:00.
// Optional DOWN_TIMER_AUTO_RELOAD_EN: reload the last loaded value on reaching zero and keep running.
module down_timer #(
    parameter int DIV_W = 32,
    parameter int MAXV  = 59
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] num,
    input  logic             load,
    input  logic [5:0]       load_min,
    input  logic [5:0]       load_sec,
    input  logic             start,
    input  logic             pause,
    output logic [5:0]       min,
    output logic [5:0]       sec,
    output logic             running,
    output logic             done,
    output logic [1:0]       state_dbg
);

    // Handshake-free control: load, start and pause are levels sampled every
    // rising edge with priority rst > load > pause > start; outputs are registered.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [5:0]       MAXV6 = 6'(MAXV);
    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);

    state_t           state;
    state_t           next_state;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic [5:0]       min_next;
    logic [5:0]       sec_next;
    logic             done_next;
    logic             tick;
    logic             nonzero;
    logic [5:0]       sat_min;
    logic [5:0]       sat_sec;
    logic [5:0]       dec_min;
    logic [5:0]       dec_sec;
    logic             dec_zero;
    logic             reload_ok;
    logic [5:0]       reload_min;
    logic [5:0]       reload_sec;

    // num of 0 or 1 both tick every cycle; a shrinking num fires on the next cycle.
    assign tick    = (num <= ONE) || (div_cnt >= (num - ONE));
    assign nonzero = (min != 6'd0) || (sec != 6'd0);
    assign sat_min = (load_min > MAXV6) ? MAXV6 : load_min;
    assign sat_sec = (load_sec > MAXV6) ? MAXV6 : load_sec;

    always_comb begin
        dec_min = min;
        dec_sec = sec;
        if (sec != 6'd0) begin
            dec_sec = sec - 6'd1;
        end else if (min != 6'd0) begin
            dec_min = min - 6'd1;
            dec_sec = MAXV6;
        end
    end

    assign dec_zero = (dec_min == 6'd0) && (dec_sec == 6'd0);

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    logic [5:0] shadow_min;
    logic [5:0] shadow_sec;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_min <= 6'd0;
            shadow_sec <= 6'd0;
        end else if (load) begin
            shadow_min <= sat_min;
            shadow_sec <= sat_sec;
        end
    end

    // An all-zero shadow cannot be reloaded, so the timer stops in DONE instead.
    assign reload_ok  = (shadow_min != 6'd0) || (shadow_sec != 6'd0);
    assign reload_min = shadow_min;
    assign reload_sec = shadow_sec;
`else
    assign reload_ok  = 1'b0;
    assign reload_min = 6'd0;
    assign reload_sec = 6'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            div_cnt <= '0;
            min     <= 6'd0;
            sec     <= 6'd0;
            done    <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= next_state;
            div_cnt <= div_next;
            min     <= min_next;
            sec     <= sec_next;
            done    <= done_next;
            running <= (next_state == RUN);
        end
    end

    always_comb begin
        next_state = state;
        if (load) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE, PAUSE: begin
                    if (!pause && start && nonzero) begin
                        next_state = RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        next_state = PAUSE;
                    end else if (tick && dec_zero && !reload_ok) begin
                        next_state = DONE;
                    end
                end
                DONE:    next_state = DONE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        min_next  = min;
        sec_next  = sec;
        div_next  = div_cnt;
        done_next = 1'b0;
        if (load) begin
            min_next = sat_min;
            sec_next = sat_sec;
            div_next = '0;
        end else if (state == RUN && !pause) begin
            if (tick) begin
                div_next = '0;
                min_next = dec_min;
                sec_next = dec_sec;
                if (dec_zero) begin
                    done_next = 1'b1;
                    if (reload_ok) begin
                        min_next = reload_min;
                        sec_next = reload_sec;
                    end
                end
            end else begin
                div_next = div_cnt + ONE;
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_down_timer.sv
// Bench for down_timer: directed scenarios plus random traffic, checked against a
// total-seconds reference model. Honours DOWN_TIMER_AUTO_RELOAD_EN like the design.
module tb_down_timer;

    localparam int DIV_W = 32;
    localparam int MAXV  = 59;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [DIV_W-1:0] num = 32'd4;
    logic             load = 1'b0;
    logic [5:0]       load_min = 6'd0;
    logic [5:0]       load_sec = 6'd0;
    logic             start = 1'b0;
    logic             pause = 1'b0;
    logic [5:0]       min;
    logic [5:0]       sec;
    logic             running;
    logic             done;
    logic [1:0]       state_dbg;

    int     total_cnt = 0;
    int     bad_cnt   = 0;
    int     m_mode    = M_IDLE;
    int     m_total   = 0;
    int     m_shadow  = 0;
    longint m_phase   = 0;
    bit     m_done    = 1'b0;
    int     done_seen = 0;

    always #5 clk = ~clk;

    down_timer #(.DIV_W(DIV_W), .MAXV(MAXV)) dut (
        .clk(clk), .rst(rst), .num(num), .load(load),
        .load_min(load_min), .load_sec(load_sec),
        .start(start), .pause(pause),
        .min(min), .sec(sec), .running(running), .done(done),
        .state_dbg(state_dbg)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input logic [5:0] v);
        return (int'(v) > MAXV) ? MAXV : int'(v);
    endfunction

    // Reference: remaining time as a single seconds count plus cycles into the current second.
    task automatic model_update();
        if (rst) begin
            m_mode = M_IDLE; m_total = 0; m_phase = 0; m_done = 0; m_shadow = 0;
        end else if (load) begin
            m_total  = sat(load_min) * (MAXV + 1) + sat(load_sec);
            m_shadow = m_total;
            m_phase  = 0; m_mode = M_IDLE; m_done = 0;
        end else begin
            m_done = 0;
            case (m_mode)
                M_IDLE, M_PAUSE: if (!pause && start && m_total != 0) m_mode = M_RUN;
                M_RUN: begin
                    if (pause) begin
                        m_mode = M_PAUSE;
                    end else if (num <= 1 || m_phase >= longint'(num) - 1) begin
                        m_phase = 0;
                        m_total = m_total - 1;
                        if (m_total == 0) begin
                            m_done = 1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                            if (m_shadow != 0) m_total = m_shadow;
                            else m_mode = M_DONE;
`else
                            m_mode = M_DONE;
`endif
                        end
                    end else begin
                        m_phase = m_phase + 1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        if (done) done_seen++;
        check("min", min, m_total / (MAXV + 1));
        check("sec", sec, m_total % (MAXV + 1));
        check("running", running, (m_mode == M_RUN) ? 1 : 0);
        check("done", done, m_done);
    endtask

    task automatic drive(input bit r, input bit l, input int lm, input int ls,
                         input bit st, input bit pa, input int n);
        rst = r; load = l; load_min = 6'(lm); load_sec = 6'(ls);
        start = st; pause = pa;
        repeat (n) step();
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, n);
    endtask

    initial begin
        // reset state
        drive(1, 0, 0, 0, 0, 0, 2);
        check("reset_min", min, 0);
        check("reset_run", running, 0);

        // reset mid-run
        num = 32'd4;
        drive(0, 1, 0, 5, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 1);
        idle(6);
        drive(1, 0, 0, 0, 0, 0, 2);
        check("rst_mid_sec", sec, 0);
        check("rst_mid_run", running, 0);
        check("rst_mid_done", done, 0);

        // 01:02 full countdown, first decrement after num cycles
        drive(0, 1, 1, 2, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 1);
        idle(3);
        check("lat_early_sec", sec, 2);
        idle(1);
        check("lat_min", min, 1);
        check("lat_sec", sec, 1);
        done_seen = 0;
        idle(4 * 61 + 10);
        check("cd_done_pulses", done_seen, 1);
`ifndef DOWN_TIMER_AUTO_RELOAD_EN
        check("cd_hold_sec", sec, 0);
        check("cd_hold_run", running, 0);
        drive(0, 0, 0, 0, 1, 0, 3);
        check("done_ignores_start", running, 0);
`endif

        // saturation and start at 00:00
        drive(0, 1, 63, 60, 0, 0, 1);
        check("sat_min", min, 59);
        check("sat_sec", sec, 59);
        drive(0, 1, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 3);
        check("zero_start_run", running, 0);

        // pause keeps the partial second
        drive(0, 1, 0, 5, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 1);
        idle(4);
        check("p_first_sec", sec, 4);
        idle(2);
        drive(0, 0, 0, 0, 0, 1, 10);
        check("p_hold_sec", sec, 4);
        check("p_hold_run", running, 0);
        drive(0, 0, 0, 0, 1, 1, 2);
        check("p_both_run", running, 0);
        drive(0, 0, 0, 0, 1, 0, 1);
        idle(1);
        check("resume_1", sec, 4);
        idle(1);
        check("resume_2", sec, 3);

        // num 1 and 0 tick every cycle
        for (int k = 0; k < 2; k++) begin
            num = (k == 0) ? 32'd1 : 32'd0;
            drive(0, 1, 0, 3, 0, 0, 1);
            drive(0, 0, 0, 0, 1, 0, 1);
            idle(2);
            check("fast_sec", sec, 1);
            idle(1);
            check("fast_done", done, 1);
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
            check("fast_reload", sec, 3);
`else
            check("fast_zero", sec, 0);
`endif
        end
        drive(0, 1, 0, 3, 1, 0, 1);
        idle(2);
        check("load_beats_start", running, 0);

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
        num = 32'd1;
        drive(0, 1, 0, 2, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 1);
        done_seen = 0;
        idle(6);
        check("ar_pulses", done_seen, 3);
        check("ar_run", running, 1);
`endif

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            int lm;
            int ls;
            r = $urandom_range(0, 999);
            if ($urandom_range(0, 49) == 0) num = 32'($urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0) begin
                lm = $urandom_range(0, 63); ls = $urandom_range(0, 63);
            end else begin
                lm = 0; ls = $urandom_range(0, 6);
            end
            drive(r < 5, r >= 5 && r < 25, lm, ls,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, 1);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
